mem_access_stage: RTL

- MEM stage logic between the EX/MEM pipeline register and the MEM/WB register.
- Consumes EX/MEM control and data outputs, runs a req/ready handshake with the data memory, and resolves branch/jump selection.
- Drives a stall that freezes PC, IF/ID, ID/EX and EX/MEM (their write=0) while an access is outstanding.
- Presents load data and the writeback controls to MEM/WB.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_access_stage_branch_resolve.sv | 31 +++
 rtl/mem_access_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: PCsrc selector values and access FSM states.
package mem_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_branch_resolve.sv
// Combinational branch/jump resolution; the redirect is suppressed while the pipe is held.
module branch_resolve
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [1:0]            PCsrc_in,
  input  logic                  zero_in,
  input  logic [ADDR_WIDTH-1:0] PC_in,
  input  logic                  stall,
  output logic                  pc_sel,
  output logic [ADDR_WIDTH-1:0] branch_target
);

  logic taken_s;

  // Decode the PCsrc selector; the reserved code behaves like sequential fetch.
  always_comb begin
    taken_s = 1'b0;
    case (PCsrc_in)
      PCSRC_SEQ: taken_s = 1'b0;
      PCSRC_BR:  taken_s = zero_in;
      PCSRC_JMP: taken_s = 1'b1;
      default:   taken_s = 1'b0;
    endcase
  end

  assign pc_sel        = taken_s & ~stall;
  assign branch_target = PC_in;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory req/ready handshake, load data register and WB controls.
// Optional macro MEM_ALIGN_CHECK_EN adds a misaligned-access check and misalign_fault output.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      MemRead_in,
  input  logic                      MemWrite_in,
  input  logic [1:0]                PCsrc_in,
  input  logic                      zero_in,
  input  logic [DATA_WIDTH-1:0]     ALU_result_in,
  input  logic [DATA_WIDTH-1:0]     data_in_1,
  input  logic [ADDR_WIDTH-1:0]     PC_in,
  input  logic                      RegWrite_in,
  input  logic                      MemtoReg_in,
  input  logic [REG_ADDR_WIDTH-1:0] Dest_Reg_Addr_in,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_ready,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic [DATA_WIDTH-1:0]     ALU_result_out,
  output logic                      RegWrite_out,
  output logic                      MemtoReg_out,
  output logic [REG_ADDR_WIDTH-1:0] Dest_Reg_Addr_out,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                      misalign_fault,
`endif
  output logic                      pc_sel,
  output logic [ADDR_WIDTH-1:0]     branch_target,
  output logic                      stall
);

  mem_state_e            state_r;
  mem_state_e            next_state_s;
  logic                  access_s;
  logic                  misalign_s;
  logic                  mem_req_s;
  logic                  stall_s;
  logic [DATA_WIDTH-1:0] read_data_r;

`ifdef MEM_ALIGN_CHECK_EN
  // A misaligned access never reaches memory and is retired as a bubble.
  assign misalign_s     = (MemRead_in | MemWrite_in) & (ALU_result_in[1:0] != 2'b00);
  assign misalign_fault = misalign_s;
`else
  assign misalign_s = 1'b0;
`endif

  assign access_s = (MemRead_in | MemWrite_in) & ~misalign_s;

  // Access state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state and handshake outputs; DONE releases the stall so EX/MEM can move on.
  always_comb begin
    next_state_s = state_r;
    mem_req_s    = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          mem_req_s = 1'b1;
          stall_s   = 1'b1;
          if (mem_ready) begin
            next_state_s = DONE;
          end else begin
            next_state_s = WAIT;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        mem_req_s = 1'b1;
        stall_s   = 1'b1;
        if (mem_ready) begin
          next_state_s = DONE;
        end else begin
          next_state_s = WAIT;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Capture load data on the completing edge of a read; writes (incl. read+write) leave it alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_data_r <= {DATA_WIDTH{1'b0}};
    end else if (mem_req_s && mem_ready && !MemWrite_in) begin
      read_data_r <= mem_rdata;
    end else begin
      read_data_r <= read_data_r;
    end
  end

  assign mem_req           = mem_req_s;
  assign stall             = stall_s;
  assign mem_we            = MemWrite_in;
  assign mem_addr          = ALU_result_in[ADDR_WIDTH-1:0];
  assign mem_wdata         = data_in_1;
  assign read_data         = read_data_r;
  assign ALU_result_out    = ALU_result_in;
  assign MemtoReg_out      = MemtoReg_in;
  assign Dest_Reg_Addr_out = Dest_Reg_Addr_in;
  assign RegWrite_out      = RegWrite_in & ~stall_s & ~misalign_s;

  branch_resolve #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_branch_resolve (
    .PCsrc_in     (PCsrc_in),
    .zero_in      (zero_in),
    .PC_in        (PC_in),
    .stall        (stall_s),
    .pc_sel       (pc_sel),
    .branch_target(branch_target)
  );

endmodule
